// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the issue stage and its three neighbours:
// command producer, 4-bit ALU and result consumer.
// Optional: ALU_ISSUE_ZFLAG_EN adds the res_z zero flag.
interface alu_issue_stage_if;
    // Command producer -> stage
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    // Stage <-> ALU
    logic       alu_e;
    logic [1:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;
    logic       alu_c;
    // Stage -> result consumer
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_y;
    logic       res_c;
    logic [1:0] res_op;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic       res_z;
`endif

    // Environment side: producer, ALU and consumer.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_c, res_ready,
        input  cmd_ready, alu_e, alu_s, alu_a, alu_b, res_valid, res_y, res_c, res_op
`ifdef ALU_ISSUE_ZFLAG_EN
        , input res_z
`endif
    );

    // Issue stage side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_c, res_ready,
        output cmd_ready, alu_e, alu_s, alu_a, alu_b, res_valid, res_y, res_c, res_op
`ifdef ALU_ISSUE_ZFLAG_EN
        , output res_z
`endif
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Command FIFO and issue stage in front of the 4-bit ALU decoder. Queues
// {op,a,b} commands, issues the head to the ALU when the result register can
// take it, and captures the ALU result behind a valid/ready handshake.
// Optional: define ALU_ISSUE_ZFLAG_EN to add the res_z (alu_y == 0) flag.
module alu_issue_stage #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_issue_stage_if.slave        bus,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [0:0] {StEmpty, StFull} res_state_e;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    res_state_e    res_state_q;
    logic [3:0]    res_y_q;
    logic          res_c_q;
    logic [1:0]    res_op_q;

    cmd_t          head;
    logic          cmd_ready;
    logic          push;
    logic          issue;

    // Handshake decode; cmd_ready ignores a same-cycle pop on purpose.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        cmd_ready = (count_q < FullCnt);
        push      = bus.cmd_valid && cmd_ready;
        issue     = (count_q != '0) && ((res_state_q == StEmpty) || bus.res_ready);
    end

    // ALU drive and result outputs; ALU inputs are forced to 0 outside issue cycles.
    always_comb begin
        bus.cmd_ready = cmd_ready;
        bus.alu_e     = issue;
        bus.alu_s     = issue ? head.op : 2'b00;
        bus.alu_a     = issue ? head.a  : 4'h0;
        bus.alu_b     = issue ? head.b  : 4'h0;
        bus.res_valid = (res_state_q == StFull);
        bus.res_y     = res_y_q;
        bus.res_c     = res_c_q;
        bus.res_op    = res_op_q;
        count         = count_q;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
        end
    end

    // Pointers wrap modulo DEPTH; count tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, issue})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Result register FSM: load on issue, empty on delivery, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_state_q <= StEmpty;
            res_y_q     <= 4'h0;
            res_c_q     <= 1'b0;
            res_op_q    <= 2'b00;
        end else if (issue) begin
            res_state_q <= StFull;
            res_y_q     <= bus.alu_y;
            res_c_q     <= bus.alu_c;
            res_op_q    <= head.op;
        end else if (bus.res_ready) begin
            res_state_q <= StEmpty;
        end
    end

`ifdef ALU_ISSUE_ZFLAG_EN
    logic res_z_q;

    // Zero flag shares the load/hold rules of res_y.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_z_q <= 1'b0;
        end else if (issue) begin
            res_z_q <= (bus.alu_y == 4'h0);
        end
    end

    // Zero flag output.
    always_comb begin
        bus.res_z = res_z_q;
    end
`endif

endmodule
